// File: rtl/rgb_grey_pkg.sv
// Shared weights, fixed-point scaling and mode encoding for the serial RGB-to-grey converter.
package rgb_grey_pkg;

    localparam int unsigned WEIGHT_FRAC = 8;
    localparam int unsigned W_AVG       = 85;
    localparam int unsigned W_R         = 77;
    localparam int unsigned W_G         = 150;
    localparam int unsigned W_B         = 29;

    typedef enum logic {
        MODE_AVG  = 1'b0,
        MODE_LUMA = 1'b1
    } mode_e;

endpackage

// File: rtl/rgb_grey_weigh.sv
// Combinational grey weighting: equal-weight average, or luma when RGB_GREY_LUMA_EN is defined.
module rgb_grey_weigh
    import rgb_grey_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    input  mode_e            mode,
    output logic [PIX_W-1:0] grey
);

    localparam int unsigned SUM_W  = PIX_W + 2;
    localparam int unsigned PROD_W = PIX_W + 9;

    logic [SUM_W-1:0]  sum;
    logic [PROD_W-1:0] prod;
    logic              unused_prod;

    assign sum  = SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
    assign prod = PROD_W'(sum) * PROD_W'(W_AVG);
    // 765*85 < 2^16, so the top product bit is always zero for any PIX_W
    assign unused_prod = ^{prod[PROD_W-1], prod[WEIGHT_FRAC-1:0]};

`ifdef RGB_GREY_LUMA_EN
    localparam int unsigned ACC_W = PIX_W + 8;

    logic [ACC_W-1:0] acc;
    logic             unused_acc;

    assign acc = ACC_W'(r) * ACC_W'(W_R)
               + ACC_W'(g) * ACC_W'(W_G)
               + ACC_W'(b) * ACC_W'(W_B);
    assign unused_acc = ^acc[WEIGHT_FRAC-1:0];

    always_comb begin
        grey = prod[WEIGHT_FRAC +: PIX_W];
        if (mode == MODE_LUMA) begin
            grey = acc[WEIGHT_FRAC +: PIX_W];
        end
    end
`else
    logic unused_mode;

    assign unused_mode = ^mode;
    assign grey        = prod[WEIGHT_FRAC +: PIX_W];
`endif

endmodule

// File: rtl/rgb_grey_serial.sv
// Serial RGB-to-grey converter: deserialise LSB-first channels, weigh, reserialise MSB-first.
// Luma weighting is available when RGB_GREY_LUMA_EN is defined.
module rgb_grey_serial
    import rgb_grey_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic             r_to_v_clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             pred,
    input  logic             pgreen,
    input  logic             pblu,
    input  logic             mode,
    input  logic [PIX_W-1:0] thr,
    output logic             grey,
    output logic             grey_valid,
    output logic             grey_sof,
    output logic             black,
    output logic             pix_done
);

    localparam int unsigned K_W = $clog2(PIX_W);

    logic [K_W-1:0]   k;
    logic [PIX_W-1:0] r_cap;
    logic [PIX_W-1:0] g_cap;
    logic [PIX_W-1:0] b_cap;
    logic [PIX_W-1:0] out_word;
    logic             out_loaded;

    logic             last_c;
    logic [PIX_W-1:0] r_word_c;
    logic [PIX_W-1:0] g_word_c;
    logic [PIX_W-1:0] b_word_c;
    logic [PIX_W-1:0] grey_word_c;

    assign last_c = bit_valid && (k == K_W'(PIX_W - 1));

    // The final bit bypasses the capture registers so the word completes on this edge
    assign r_word_c = {pred,   r_cap[PIX_W-2:0]};
    assign g_word_c = {pgreen, g_cap[PIX_W-2:0]};
    assign b_word_c = {pblu,   b_cap[PIX_W-2:0]};

    rgb_grey_weigh #(
        .PIX_W (PIX_W)
    ) u_weigh (
        .r    (r_word_c),
        .g    (g_word_c),
        .b    (b_word_c),
        .mode (mode_e'(mode)),
        .grey (grey_word_c)
    );

    always_ff @(posedge r_to_v_clk) begin
        if (!rst_n) begin
            k          <= '0;
            r_cap      <= '0;
            g_cap      <= '0;
            b_cap      <= '0;
            out_word   <= '0;
            out_loaded <= 1'b0;
            grey       <= 1'b0;
            grey_valid <= 1'b0;
            grey_sof   <= 1'b0;
            black      <= 1'b0;
            pix_done   <= 1'b0;
        end else begin
            grey_valid <= 1'b0;
            grey_sof   <= 1'b0;
            pix_done   <= 1'b0;
            if (bit_valid) begin
                r_cap[k] <= pred;
                g_cap[k] <= pgreen;
                b_cap[k] <= pblu;
                // Output runs one word behind, sharing the input bit index
                if (out_loaded) begin
                    grey       <= out_word[K_W'(PIX_W - 1) - k];
                    grey_valid <= 1'b1;
                    grey_sof   <= (k == '0);
                end
                if (last_c) begin
                    k          <= '0;
                    out_word   <= grey_word_c;
                    out_loaded <= 1'b1;
                    black      <= (grey_word_c > thr);
                    pix_done   <= 1'b1;
                end else begin
                    k <= k + K_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_grey_serial.sv
// Directed self-checking bench for rgb_grey_serial at PIX_W=8.
module tb_rgb_grey_serial;

    logic       clk;
    logic       rst_n;
    logic       bit_valid;
    logic       pred;
    logic       pgreen;
    logic       pblu;
    logic       mode;
    logic [7:0] thr;
    logic       grey;
    logic       grey_valid;
    logic       grey_sof;
    logic       black;
    logic       pix_done;

    int total = 0;
    int bad   = 0;

`ifdef RGB_GREY_LUMA_EN
    localparam logic [7:0] LUMA_RED = 8'h4C;
`else
    localparam logic [7:0] LUMA_RED = 8'h54;
`endif

    rgb_grey_serial #(.PIX_W(8)) dut (
        .r_to_v_clk (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .pred       (pred),
        .pgreen     (pgreen),
        .pblu       (pblu),
        .mode       (mode),
        .thr        (thr),
        .grey       (grey),
        .grey_valid (grey_valid),
        .grey_sof   (grey_sof),
        .black      (black),
        .pix_done   (pix_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: assembles serial grey words and tallies protocol events
    logic [7:0] word_q[$];
    logic       black_q[$];
    int done_cnt = 0;
    int sof_err  = 0;
    int bit_cnt  = 0;
    int gv_runs  = 0;
    int gv_err   = 0;
    int pos      = 0;
    logic prev_gv = 1'b0;
    logic [7:0] cur = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pos     = 0;
            prev_gv = 1'b0;
        end else begin
            if (grey_valid && !bit_valid) gv_err++;
            if (grey_valid && !prev_gv) gv_runs++;
            prev_gv = grey_valid;
            if (pix_done) begin
                done_cnt++;
                black_q.push_back(black);
            end
            if (grey_valid) begin
                bit_cnt++;
                if (grey_sof != (pos == 0)) sof_err++;
                if (grey_sof) pos = 0;
                cur[7-pos] = grey;
                pos++;
                if (pos == 8) begin
                    word_q.push_back(cur);
                    pos = 0;
                end
            end
        end
    end

    int wb, bb, dc0, sc0, bc0, gr0, ge0;

    task automatic snap();
        wb  = word_q.size();
        bb  = black_q.size();
        dc0 = done_cnt;
        sc0 = sof_err;
        bc0 = bit_cnt;
        gr0 = gv_runs;
        ge0 = gv_err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        snap();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid = 1'b0;
        end
    endtask

    task automatic feed_word(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            @(negedge clk);
            bit_valid = 1'b1;
            pred      = r[i];
            pgreen    = g[i];
            pblu      = b[i];
        end
    endtask

    function automatic logic [7:0] word_at(input int idx);
        return (idx < word_q.size()) ? word_q[idx] : 8'hxx;
    endfunction

    function automatic logic black_at(input int idx);
        return (idx < black_q.size()) ? black_q[idx] : 1'bx;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        total += 5;
        if (grey !== 1'b0)       begin bad++; $display("FAIL reset_grey: got %b want 0", grey); end
        if (grey_valid !== 1'b0) begin bad++; $display("FAIL reset_grey_valid: got %b want 0", grey_valid); end
        if (grey_sof !== 1'b0)   begin bad++; $display("FAIL reset_grey_sof: got %b want 0", grey_sof); end
        if (black !== 1'b0)      begin bad++; $display("FAIL reset_black: got %b want 0", black); end
        if (pix_done !== 1'b0)   begin bad++; $display("FAIL reset_pix_done: got %b want 0", pix_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_avg_mid();
        do_reset();
        thr  = 8'd100;
        mode = 1'b0;
        feed_word(8'h60, 8'h60, 8'h60, 1'b0);
        feed_word(8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        total += 5;
        if (word_q.size() - wb != 1) begin bad++; $display("FAIL avg_mid_words: got %0d want 1", word_q.size() - wb); end
        if (word_at(wb) !== 8'h5F)   begin bad++; $display("FAIL avg_mid_grey: got %h want 5f", word_at(wb)); end
        if (black_at(bb) !== 1'b0)   begin bad++; $display("FAIL avg_mid_black: got %b want 0", black_at(bb)); end
        if (done_cnt - dc0 != 2)     begin bad++; $display("FAIL avg_mid_pix_done: got %0d want 2", done_cnt - dc0); end
        if (sof_err != sc0)          begin bad++; $display("FAIL avg_mid_sof: got %0d errors want 0", sof_err - sc0); end
    endtask

    task automatic test_avg_sat();
        do_reset();
        thr  = 8'd100;
        mode = 1'b0;
        feed_word(8'hFF, 8'hFF, 8'hFF, 1'b0);
        feed_word(8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        total += 2;
        if (word_at(wb) !== 8'hFE) begin bad++; $display("FAIL avg_sat_grey: got %h want fe", word_at(wb)); end
        if (black_at(bb) !== 1'b1) begin bad++; $display("FAIL avg_sat_black: got %b want 1", black_at(bb)); end
    endtask

    task automatic test_luma();
        do_reset();
        thr  = 8'd100;
        mode = 1'b1;
        feed_word(8'hFF, 8'h00, 8'h00, 1'b0);
        feed_word(8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        total += 2;
        if (word_at(wb) !== LUMA_RED) begin bad++; $display("FAIL luma_red_grey: got %h want %h", word_at(wb), LUMA_RED); end
        if (black_at(bb) !== 1'b0)    begin bad++; $display("FAIL luma_red_black: got %b want 0", black_at(bb)); end
        do_reset();
        mode = 1'b0;
        feed_word(8'hFF, 8'h00, 8'h00, 1'b0);
        feed_word(8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        total++;
        if (word_at(wb) !== 8'h54) begin bad++; $display("FAIL avg_red_grey: got %h want 54", word_at(wb)); end
    endtask

    task automatic test_gaps();
        do_reset();
        thr  = 8'd100;
        mode = 1'b0;
        feed_word(8'h60, 8'h60, 8'h60, 1'b1);
        feed_word(8'hFF, 8'hFF, 8'hFF, 1'b1);
        feed_word(8'h00, 8'h00, 8'h00, 1'b1);
        idle(3);
        total += 7;
        if (word_at(wb) !== 8'h5F)     begin bad++; $display("FAIL gaps_grey0: got %h want 5f", word_at(wb)); end
        if (word_at(wb + 1) !== 8'hFE) begin bad++; $display("FAIL gaps_grey1: got %h want fe", word_at(wb + 1)); end
        if (black_at(bb) !== 1'b0)     begin bad++; $display("FAIL gaps_black0: got %b want 0", black_at(bb)); end
        if (black_at(bb + 1) !== 1'b1) begin bad++; $display("FAIL gaps_black1: got %b want 1", black_at(bb + 1)); end
        if (bit_cnt - bc0 != 16)       begin bad++; $display("FAIL gaps_bits: got %0d want 16", bit_cnt - bc0); end
        if (gv_err != ge0)             begin bad++; $display("FAIL gaps_valid_idle: got %0d want 0", gv_err - ge0); end
        if (sof_err != sc0)            begin bad++; $display("FAIL gaps_sof: got %0d errors want 0", sof_err - sc0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        thr  = 8'd100;
        mode = 1'b0;
        feed_word(8'hFF, 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            pred      = 1'b1;
            pgreen    = 1'b0;
            pblu      = 1'b1;
        end
        @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total += 4;
        if (grey_valid !== 1'b0) begin bad++; $display("FAIL rstmid_grey_valid: got %b want 0", grey_valid); end
        if (grey !== 1'b0)       begin bad++; $display("FAIL rstmid_grey: got %b want 0", grey); end
        if (black !== 1'b0)      begin bad++; $display("FAIL rstmid_black: got %b want 0", black); end
        if (pix_done !== 1'b0)   begin bad++; $display("FAIL rstmid_pix_done: got %b want 0", pix_done); end
        snap();
        feed_word(8'h60, 8'h60, 8'h60, 1'b0);
        feed_word(8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        total += 3;
        if (bit_cnt - bc0 != 8)    begin bad++; $display("FAIL rstmid_bits: got %0d want 8", bit_cnt - bc0); end
        if (word_at(wb) !== 8'h5F) begin bad++; $display("FAIL rstmid_grey_word: got %h want 5f", word_at(wb)); end
        if (black_at(bb) !== 1'b0) begin bad++; $display("FAIL rstmid_black_word: got %b want 0", black_at(bb)); end
    endtask

    task automatic test_threshold();
        do_reset();
        mode = 1'b0;
        thr  = 8'd95;
        feed_word(8'h60, 8'h60, 8'h60, 1'b0);
        idle(1);
        total += 2;
        if (black !== 1'b0)    begin bad++; $display("FAIL thr95_black: got %b want 0", black); end
        if (pix_done !== 1'b1) begin bad++; $display("FAIL thr95_pix_done: got %b want 1", pix_done); end
        idle(1);
        total++;
        if (pix_done !== 1'b0) begin bad++; $display("FAIL thr95_pix_done_pulse: got %b want 0", pix_done); end
        thr = 8'd94;
        feed_word(8'h60, 8'h60, 8'h60, 1'b0);
        idle(1);
        total++;
        if (black !== 1'b1) begin bad++; $display("FAIL thr94_black: got %b want 1", black); end
        idle(3);
        total++;
        if (black !== 1'b1) begin bad++; $display("FAIL thr94_black_hold: got %b want 1", black); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        thr  = 8'd100;
        mode = 1'b0;
        feed_word(8'h60, 8'h60, 8'h60, 1'b0);
        feed_word(8'hFF, 8'hFF, 8'hFF, 1'b0);
        feed_word(8'h60, 8'h60, 8'h60, 1'b0);
        feed_word(8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        total += 7;
        if (word_at(wb) !== 8'h5F)     begin bad++; $display("FAIL b2b_grey0: got %h want 5f", word_at(wb)); end
        if (word_at(wb + 1) !== 8'hFE) begin bad++; $display("FAIL b2b_grey1: got %h want fe", word_at(wb + 1)); end
        if (word_at(wb + 2) !== 8'h5F) begin bad++; $display("FAIL b2b_grey2: got %h want 5f", word_at(wb + 2)); end
        if (black_at(bb + 1) !== 1'b1) begin bad++; $display("FAIL b2b_black1: got %b want 1", black_at(bb + 1)); end
        if (black_at(bb + 2) !== 1'b0) begin bad++; $display("FAIL b2b_black2: got %b want 0", black_at(bb + 2)); end
        if (bit_cnt - bc0 != 24)       begin bad++; $display("FAIL b2b_bits: got %0d want 24", bit_cnt - bc0); end
        if (gv_runs - gr0 != 1)        begin bad++; $display("FAIL b2b_valid_runs: got %0d want 1", gv_runs - gr0); end
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        pred      = 1'b0;
        pgreen    = 1'b0;
        pblu      = 1'b0;
        mode      = 1'b0;
        thr       = 8'd0;
        test_reset();
        test_avg_mid();
        test_avg_sat();
        test_luma();
        test_gaps();
        test_reset_mid();
        test_threshold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_grey_serial.md
# rgb_grey_serial

Parametrised successor to the team's serial RGB-to-grey converter. It deserialises three one-bit colour streams (LSB first) into PIX_W-bit channel words and computes a grey level by either equal-weight averaging or BT.601-style luma weighting. It serialises the grey word back out MSB first and raises a registered "black" flag against a programmable threshold. It sits between the pixel-bit source and the downstream grey/threshold consumers, paced by a per-bit valid qualifier.

## Interface
- PIX_W, 8, bits per colour channel and per grey word (legal 4..12)
- r_to_v_clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- bit_valid  in  1  pred/pgreen/pblu carry a valid bit this cycle
- pred  in  1  red serial bit, LSB first
- pgreen  in  1  green serial bit, LSB first
- pblu  in  1  blue serial bit, LSB first
- mode  in  1  0 = average, 1 = luma (honoured only with RGB_GREY_LUMA_EN)
- thr  in  PIX_W  black threshold
- grey  out  1  serial grey bit, MSB first
- grey_valid  out  1  grey carries a valid bit
- grey_sof  out  1  grey carries the MSB of a word
- black  out  1  1 when last computed grey word > thr
- pix_done  out  1  one-cycle pulse: a new grey word was computed

## Operation
- Bit counter `k`, 0..PIX_W-1, advances only on cycles with bit_valid=1. Bit `k` of each channel is written into capture registers r/g/b[k].
- Completion: on the accepted bit with `k`=PIX_W-1, the weigh unit uses the captured bits plus the incoming bit.
  - The result loads out_word, black, and sets out_loaded.
  - mode and thr are sampled on this same edge. `k` wraps to 0.
- Average: grey = ((r+g+b)·85) >> 8. Sum is PIX_W+2 bits; product is PIX_W+9 bits.
- Luma: grey = (77r + 150g + 29b) >> 8. Accumulator is PIX_W+8 bits. Weights sum to 256, so the result never exceeds 2^PIX_W−1.
- Truncation only; no rounding. Neither mode can overflow PIX_W bits.
- Output serialiser, on each accepted input bit while out_loaded=1:
  - grey ← out_word[PIX_W−1−k]
  - grey_valid ← 1
  - grey_sof ← (k==0)
- Cycles with bit_valid=0: the counter, capture registers, out_word and grey hold; grey_valid and grey_sof go 0.
- black = (grey_word > thr), strict compare. It is held until the next completion.
- Before the first completion after reset, grey_valid stays 0.

## Timing
- Reset values: grey=0, grey_valid=0, grey_sof=0, black=0, pix_done=0, `k`=0, out_loaded=0, capture/out_word=0.
- Reset mid-word discards the partial word. The next accepted bit is bit 0 of a fresh word.
- black and pix_done update on the completing edge, so they are visible the cycle after the last input bit.
- Serial latency: bit `j` of word N's grey appears one cycle after bit `j` of word N+1 is accepted. This is one word of latency and keeps input/output paces identical.
- Back-to-back words with continuous bit_valid produce continuous grey_valid with no bubbles.
- Completion and serialisation share an edge. The bit shifted out on the completing edge is the old out_word's LSB; the new word starts on the next accepted bit.

## Configuration
- RGB_GREY_LUMA_EN defined:
  - Luma multipliers are compiled in.
  - mode is sampled at completion and selects average (0) or luma (1).
- RGB_GREY_LUMA_EN undefined:
  - Luma logic is absent and mode is ignored.
  - Every word uses the average formula.

## Structure
- Package rgb_grey_pkg holds:
  - WEIGHT_FRAC=8
  - W_AVG=85, W_R=77, W_G=150, W_B=29
  - mode enum: MODE_AVG, MODE_LUMA
- Sub-module rgb_grey_weigh: purely combinational; inputs r/g/b words and mode; output PIX_W-bit grey. Its luma path is under the macro.
- Top level holds the counter, capture registers, out_word, serialiser and threshold compare.

## Test plan
All scenarios use PIX_W=8 and continuous bit_valid unless stated.
- Average mid-level: r=g=b=0x60, thr=100 → grey word 0x5F (95), black=0, pix_done one pulse, next word's slot emits 01011111 with grey_sof on the first bit.
- Average saturation: r=g=b=0xFF, thr=100 → grey 0xFE (254), black=1, serial 11111110.
- Luma red, macro on, mode=1: r=0xFF, g=b=0 → grey 0x4C (76), serial 01001100. Same stimulus with macro off → 0x54 (84).
- Valid gaps: the first two scenarios' words with bit_valid deasserted on random cycles → identical grey words and black. grey_valid is high only on accepted cycles; no bits are lost or duplicated.
- Reset mid-word: 3 bits in, rst_n low for 1 cycle → all outputs 0 next cycle, grey_valid stays 0 through the next full word, and the following 8 bits form a correct fresh word.
- Threshold boundary: grey word 95 with thr=95 → black=0; thr=94 → black=1.
